// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared widths, reset divisor and channel state encoding for the divider bank
package clk_div_pkg;
  localparam int CLK_DIV_CW = 16;
  localparam int CLK_DIV_DEF = 10000;
  localparam int MIN_DIV = 2;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } st_e;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with shadow/active divisor, glitch-free reload at period wrap
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW = CLK_DIV_CW,
  parameter int DEF_DIV = CLK_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          sync,
  input  logic [CW-1:0] div_in,
  output logic          clk_out,
  output logic          tick,
  output logic          running
);
  st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n, act, act_n, shd, shd_n;
  logic wrap, on;
  always_comb begin
    shd_n = load ? div_in : shd;
    act_n = act;
    cnt_n = '0;
    wrap = (st != ST_IDLE) && (cnt == act - CW'(1) || sync);
    if (st == ST_IDLE) begin
      act_n = load ? div_in : act;
      st_n = (en && act_n >= CW'(MIN_DIV)) ? ST_RUN : ST_IDLE;
    end else if (wrap) begin
      // the pre-edge shadow applies, so a load landing on the wrap waits one more period
      act_n = shd;
      st_n = (en && shd >= CW'(MIN_DIV)) ? ST_RUN : ST_IDLE;
    end else begin
      cnt_n = cnt + CW'(1);
      st_n = en ? ST_RUN : ST_DRAIN;
    end
    on = st_n != ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      act <= CW'(DEF_DIV);
      shd <= CW'(DEF_DIV);
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      act <= act_n;
      shd <= shd_n;
      clk_out <= on && cnt_n < act_n - (act_n >> 1);
      tick <= on && cnt_n == act_n - CW'(1);
    end
  end
  assign running = st != ST_IDLE;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH independent programmable clock dividers; CLK_DIV_SYNC_EN adds a common phase-realign strobe
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = CLK_DIV_CW,
  parameter int DEF_DIV = CLK_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   load,
  input  logic [CH*CW-1:0] div_val,
`ifdef CLK_DIV_SYNC_EN
  input  logic            sync,
`endif
  output logic [CH-1:0]   clk_out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   running
);
  logic sync_i;
`ifdef CLK_DIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    clk_div_chan #(.CW(CW), .DEF_DIV(DEF_DIV)) u_chan (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .load(load[i]),
      .sync(sync_i),
      .div_in(div_val[i*CW +: CW]),
      .clk_out(clk_out[i]),
      .tick(tick[i]),
      .running(running[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: scoreboard bench for clk_div_bank; define CLK_DIV_SYNC_EN to exercise sync
module tb_clk_div_bank;
  localparam int CH = 4;
  localparam int CW = 16;
  localparam int DEF = 10;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sync = 1'b0;
  logic [CH-1:0] en = '0, load = '0;
  logic [CH*CW-1:0] div_val = '0;
  logic [CH-1:0] clk_out, tick, running;
  int errs = 0, checks = 0;
  int m_st[CH], m_cnt[CH], m_act[CH], m_shd[CH];
  logic [3*CH-1:0] exp_q[$];
  int hi, tk, n;

  always #5 clk = ~clk;

  clk_div_bank #(.CH(CH), .CW(CW), .DEF_DIV(DEF)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .div_val(div_val),
`ifdef CLK_DIV_SYNC_EN
    .sync(sync),
`endif
    .clk_out(clk_out),
    .tick(tick),
    .running(running)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_st[i] = 0;
      m_cnt[i] = 0;
      m_act[i] = DEF;
      m_shd[i] = DEF;
    end
  endtask

  task automatic set_div(input int ch, input int d);
    div_val[ch*CW +: CW] = CW'(d);
  endtask

  // one clock: advance the reference model, queue its prediction, then compare after the edge
  task automatic cyc();
    logic [3*CH-1:0] e, g;
    int d, old_shd;
    bit last;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      d = int'(div_val[i*CW +: CW]);
      if (m_st[i] == 0) begin
        if (load[i]) begin
          m_shd[i] = d;
          m_act[i] = d;
        end
        if (en[i] && m_act[i] >= 2) begin
          m_st[i] = 1;
          m_cnt[i] = 0;
        end
      end else begin
        last = (m_cnt[i] == m_act[i] - 1) || sync;
        old_shd = m_shd[i];
        if (load[i]) m_shd[i] = d;
        if (last) begin
          m_act[i] = old_shd;
          m_cnt[i] = 0;
          m_st[i] = (en[i] && m_act[i] >= 2) ? 1 : 0;
        end else begin
          m_cnt[i]++;
          m_st[i] = en[i] ? 1 : 2;
        end
      end
      if (m_st[i] != 0) begin
        e[i] = m_cnt[i] < (m_act[i] + 1) / 2;
        e[CH+i] = m_cnt[i] == m_act[i] - 1;
        e[2*CH+i] = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = {running, tick, clk_out};
    e = exp_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("clk_out[%0d]", i), int'(g[i]), int'(e[i]));
      check($sformatf("tick[%0d]", i), int'(g[CH+i]), int'(e[CH+i]));
      check($sformatf("running[%0d]", i), int'(g[2*CH+i]), int'(e[2*CH+i]));
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_running", int'(running), 0);
    rst = 1'b1;
    // default divisor 10: 5 high / 5 low, tick once per 10
    en[0] = 1'b1;
    cyc();
    hi = 0;
    tk = 0;
    repeat (20) begin
      hi += int'(clk_out[0]);
      tk += int'(tick[0]);
      cyc();
    end
    check("t1_high", hi, 10);
    check("t1_ticks", tk, 2);
    // idle loads: D=7, D=2, D=1, then D=0
    set_div(1, 7);
    set_div(2, 2);
    set_div(3, 1);
    load[3:1] = 3'b111;
    cyc();
    load = '0;
    en[3:1] = 3'b111;
    cyc();
    hi = 0;
    tk = 0;
    repeat (14) begin
      hi += int'(clk_out[1]);
      tk += int'(clk_out[2]);
      cyc();
    end
    check("t2_d7_high", hi, 8);
    check("t2_d2_high", tk, 7);
    check("t2_d1_idle", int'(running[3]), 0);
    set_div(3, 0);
    load[3] = 1'b1;
    cyc();
    load = '0;
    repeat (3) cyc();
    check("t2_d0_idle", int'(running[3] | clk_out[3]), 0);
    // mid-period reload on ch0: current period finishes at 10, next is 4
    n = 0;
    while (m_cnt[0] != 3 && n < 40) begin
      cyc();
      n++;
    end
    check("t3_align", m_cnt[0], 3);
    set_div(0, 4);
    load[0] = 1'b1;
    n = 0;
    do begin
      cyc();
      load = '0;
      n++;
    end while (!tick[0] && n < 50);
    check("t3_gap_old", n, 6);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[0] && n < 50);
    check("t3_gap_new", n, 4);
    // drain: en drops at cnt=2 with D=10
    set_div(0, 10);
    load[0] = 1'b1;
    cyc();
    load = '0;
    n = 0;
    while (!(m_cnt[0] == 2 && m_act[0] == 10) && n < 40) begin
      cyc();
      n++;
    end
    check("t4_align", m_cnt[0], 2);
    en[0] = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[0] && n < 50);
    check("t4_drain_len", n, 7);
    check("t4_running_at_tick", int'(running[0]), 1);
    cyc();
    check("t4_idle", int'(running[0] | clk_out[0]), 0);
    // async reset mid-period on all channels
    en = 4'b1111;
    repeat (7) cyc();
    #3 rst = 1'b0;
    #1;
    check("t5_clk_out", int'(clk_out), 0);
    check("t5_tick", int'(tick), 0);
    check("t5_running", int'(running), 0);
    model_reset();
    #2 rst = 1'b1;
    cyc();
    tk = 0;
    repeat (20) begin
      tk += int'(tick[3]);
      cyc();
    end
    check("t5_def_div_ticks", tk, 2);
`ifdef CLK_DIV_SYNC_EN
    set_div(0, 6);
    set_div(1, 9);
    load[1:0] = 2'b11;
    cyc();
    load = '0;
    repeat (23) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    check("t6_sync_clk0", int'(clk_out[0]), 1);
    check("t6_sync_clk1", int'(clk_out[1]), 1);
    n = 1;
    while (!tick[0] && n < 50) begin
      cyc();
      n++;
    end
    check("t6_ch0_tick", n, 6);
    while (!tick[1] && n < 50) begin
      cyc();
      n++;
    end
    check("t6_ch1_tick", n, 9);
`endif
    repeat (5) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
